// File: rtl/mips_pkg.sv
// Shared definitions for the store-bus monitor.
// State encoding, fail codes and default address/data values.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2
  } mon_state_e;

  localparam logic [1:0] FAIL_NONE    = 2'b00;
  localparam logic [1:0] FAIL_STORE   = 2'b01;
  localparam logic [1:0] FAIL_TIMEOUT = 2'b10;

  localparam logic [31:0] DEF_PASS_ADDR    = 32'd84;
  localparam logic [31:0] DEF_PASS_DATA    = 32'd7;
  localparam logic [31:0] DEF_ALLOWED_ADDR = 32'd80;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, first-word fall-through, wrap-bit pointers.
// A push on a full FIFO is accepted only if a pop frees the slot.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic             empty_o,
  output logic             drop_o,
  output logic [WIDTH-1:0] dout_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             full;
  logic             push_ok;
  logic             pop_ok;

  assign empty_o = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full || pop_ok);
  assign drop_o  = push_i && full && !pop_ok;
  assign dout_o  = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_ok) wr_d = wr_q + (AW+1)'(1);
    if (pop_ok)  rd_d = rd_q + (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push_ok) mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/store_monitor.sv
// Store-bus checker for the single-cycle MIPS core: classifies
// stores, enforces a run timeout and keeps a trace of stores.
module store_monitor
  import mips_pkg::*;
#(
  parameter logic [31:0] PASS_ADDR    = DEF_PASS_ADDR,
  parameter logic [31:0] PASS_DATA    = DEF_PASS_DATA,
  parameter logic [31:0] ALLOWED_ADDR = DEF_ALLOWED_ADDR,
  parameter int          TIMEOUT      = 1000,
  parameter int          TRACE_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic        done,
  output logic        pass,
  output logic [1:0]  fail_code,
  output logic [31:0] cycle_count,
  output logic [15:0] store_count,
  input  logic        trace_pop,
  output logic        trace_valid,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data,
  output logic        trace_overflow
);

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

  mon_state_e  state_q, state_d;
  logic [1:0]  fail_q, fail_d;
  logic [31:0] cyc_q, cyc_d;
  logic [15:0] st_q, st_d;
  logic        done_q, pass_q;
  logic        ovf_q;
  logic        push;
  logic        drop;
  logic        empty;
  logic [63:0] head;

  always_comb begin
    state_d = state_q;
    fail_d  = fail_q;
    cyc_d   = cyc_q;
    st_d    = st_q;
    push    = 1'b0;
    if (state_q == ST_RUN) begin
      if (memwrite) begin
        push  = 1'b1;
        cyc_d = cyc_q + 32'd1;
        if (st_q != 16'hFFFF) st_d = st_q + 16'd1;
        unique case (1'b1)
          (dataadr == PASS_ADDR) && (writedata == PASS_DATA):
            state_d = ST_PASS;
          (dataadr == ALLOWED_ADDR):
            state_d = ST_RUN;
          default: begin
            state_d = ST_FAIL;
            fail_d  = FAIL_STORE;
          end
        endcase
      end else if (cyc_q >= TO_LAST) begin
        // timeout cycle itself is not counted
        state_d = ST_FAIL;
        fail_d  = FAIL_TIMEOUT;
      end else begin
        cyc_d = cyc_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_RUN;
      fail_q  <= FAIL_NONE;
      cyc_q   <= '0;
      st_q    <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fail_q  <= fail_d;
      cyc_q   <= cyc_d;
      st_q    <= st_d;
      done_q  <= (state_d != ST_RUN);
      pass_q  <= (state_d == ST_PASS);
      ovf_q   <= ovf_q | drop;
    end
  end

  sync_fifo #(
    .WIDTH (64),
    .DEPTH (TRACE_DEPTH)
  ) u_trace (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push),
    .din_i   ({dataadr, writedata}),
    .pop_i   (trace_pop),
    .empty_o (empty),
    .drop_o  (drop),
    .dout_o  (head)
  );

  assign done           = done_q;
  assign pass           = pass_q;
  assign fail_code      = fail_q;
  assign cycle_count    = cyc_q;
  assign store_count    = st_q;
  assign trace_overflow = ovf_q;
  assign trace_valid    = !empty;
  assign trace_addr     = head[63:32];
  assign trace_data     = head[31:0];

endmodule

// File: tb/tb_store_monitor.sv
// Directed bench for store_monitor (TIMEOUT=20, depth 8).
// Inputs change #1 after the rising edge; outputs checked there too.
module tb_store_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic        done;
  logic        pass;
  logic [1:0]  fail_code;
  logic [31:0] cycle_count;
  logic [15:0] store_count;
  logic        trace_pop;
  logic        trace_valid;
  logic [31:0] trace_addr;
  logic [31:0] trace_data;
  logic        trace_overflow;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  store_monitor #(
    .TIMEOUT     (20),
    .TRACE_DEPTH (8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .memwrite       (memwrite),
    .dataadr        (dataadr),
    .writedata      (writedata),
    .done           (done),
    .pass           (pass),
    .fail_code      (fail_code),
    .cycle_count    (cycle_count),
    .store_count    (store_count),
    .trace_pop      (trace_pop),
    .trace_valid    (trace_valid),
    .trace_addr     (trace_addr),
    .trace_data     (trace_data),
    .trace_overflow (trace_overflow)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    memwrite  = 1'b1;
    dataadr   = a;
    writedata = d;
  endtask

  task automatic idle();
    memwrite  = 1'b0;
    trace_pop = 1'b0;
    dataadr   = '0;
    writedata = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    #2;
    do_reset();
    check("rst_done", 32'(done), 0);
    check("rst_pass", 32'(pass), 0);
    check("rst_code", 32'(fail_code), 0);
    check("rst_cyc", cycle_count, 0);
    check("rst_sc", 32'(store_count), 0);
    check("rst_tv", 32'(trace_valid), 0);
    check("rst_ovf", 32'(trace_overflow), 0);

    // allowed store, then the pass store
    store(32'd80, 32'd5);
    step();
    check("a_done", 32'(done), 0);
    check("a_tv", 32'(trace_valid), 1);
    check("a_addr", trace_addr, 80);
    check("a_data", trace_data, 5);
    store(32'd84, 32'd7);
    step();
    idle();
    check("p_done", 32'(done), 1);
    check("p_pass", 32'(pass), 1);
    check("p_code", 32'(fail_code), 0);
    check("p_sc", 32'(store_count), 2);
    check("p_cyc", cycle_count, 2);
    check("p_h0a", trace_addr, 80);
    check("p_h0d", trace_data, 5);
    trace_pop = 1'b1;
    step();
    check("p_h1a", trace_addr, 84);
    check("p_h1d", trace_data, 7);
    step();
    trace_pop = 1'b0;
    check("p_tv0", 32'(trace_valid), 0);
    step();
    check("p_sc_frz", 32'(store_count), 2);

    // wrong data at the pass address
    do_reset();
    store(32'd84, 32'd6);
    step();
    check("w_done", 32'(done), 1);
    check("w_pass", 32'(pass), 0);
    check("w_code", 32'(fail_code), 1);
    store(32'd84, 32'd7);
    step();
    idle();
    check("w_pass2", 32'(pass), 0);
    check("w_code2", 32'(fail_code), 1);
    check("w_sc", 32'(store_count), 1);
    check("w_cyc", cycle_count, 1);

    // timeout with no stores
    do_reset();
    for (int i = 0; i < 19; i++) step();
    check("t_cyc19", cycle_count, 19);
    check("t_done19", 32'(done), 0);
    step();
    check("t_done", 32'(done), 1);
    check("t_code", 32'(fail_code), 2);
    check("t_cyc", cycle_count, 19);
    step();
    step();
    check("t_frz", cycle_count, 19);

    // pass store on the would-be timeout cycle
    do_reset();
    for (int i = 0; i < 19; i++) step();
    store(32'd84, 32'd7);
    step();
    idle();
    check("tp_pass", 32'(pass), 1);
    check("tp_code", 32'(fail_code), 0);
    check("tp_cyc", cycle_count, 20);

    // overflow: 10 stores into 8 slots, then push+pop on full
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      store(32'd80, 32'(i));
      step();
      if (i == 8) check("o_ovf8", 32'(trace_overflow), 0);
    end
    check("o_ovf", 32'(trace_overflow), 1);
    check("o_sc", 32'(store_count), 10);
    check("o_head", trace_data, 1);
    store(32'd80, 32'd11);
    trace_pop = 1'b1;
    step();
    memwrite = 1'b0;
    check("o_sc11", 32'(store_count), 11);
    check("o_h2", trace_data, 2);
    for (int i = 3; i <= 8; i++) begin
      step();
      check("o_drain", trace_data, 32'(i));
    end
    step();
    trace_pop = 1'b0;
    check("o_kept", trace_data, 11);
    check("o_tv", 32'(trace_valid), 1);
    check("o_done", 32'(done), 0);
    check("o_ovf2", 32'(trace_overflow), 1);

    // reset with a store and pop presented in the same cycle
    store(32'd99, 32'd1);
    trace_pop = 1'b1;
    reset = 1'b0;
    step();
    reset = 1'b1;
    idle();
    check("r_done", 32'(done), 0);
    check("r_code", 32'(fail_code), 0);
    check("r_cyc", cycle_count, 0);
    check("r_sc", 32'(store_count), 0);
    check("r_tv", 32'(trace_valid), 0);
    check("r_ovf", 32'(trace_overflow), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
